// File: rtl/sw_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce_pkg
// Purpose  : Shared types and constants for the three-input switch debouncer.
// Revision : 1.0 - initial release
// ============================================================================
package sw_debounce_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } db_state_t;

  localparam int NUM_SW                  = 3;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage : sw_debounce_pkg
`default_nettype wire

// File: rtl/sw_debounce3_chan.sv
`default_nettype none
// ============================================================================
// Module   : debounce_chan
// Purpose  : Two-flop synchroniser plus counting debounce FSM for one switch.
//            With SW_DEBOUNCE_RISE_EN defined it also exports the 0->1 accept
//            event so the parent can register a rising-edge strobe.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_chan
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
`ifdef SW_DEBOUNCE_RISE_EN
  output logic rise_set,
`endif
  output logic db,
  output logic busy
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  db_state_t        r_state;

  logic w_diff;
  logic w_at_last;

  assign w_diff    = r_s2 ^ r_db;
  assign w_at_last = (r_cnt == c_cnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
      r_state <= STABLE;
    end else begin
      r_s1 <= sw;
      r_s2 <= r_s1;
      case (r_state)
        STABLE: begin
          if (w_diff) begin
            r_state <= CHANGING;
            r_cnt   <= c_cnt_one;
          end else begin
            r_cnt   <= '0;
          end
        end
        CHANGING: begin
          // A bounce back to the held level abandons the count without
          // touching db; only an uninterrupted run reaches the terminal value.
          if (!w_diff) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end else if (w_at_last) begin
            r_db    <= r_s2;
            r_cnt   <= '0;
            r_state <= STABLE;
          end else begin
            r_cnt   <= r_cnt + c_cnt_one;
          end
        end
        default: begin
          r_state <= STABLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign db   = r_db;
  assign busy = (r_state == CHANGING);

`ifdef SW_DEBOUNCE_RISE_EN
  // Asserted in the cycle whose closing edge loads a 1 into db, so a register
  // in the parent lines its pulse up with the first cycle of db high.
  assign rise_set = (r_state == CHANGING) & w_diff & w_at_last & r_s2;
`endif

endmodule : debounce_chan
`default_nettype wire

// File: rtl/sw_debounce3.sv
`default_nettype none
// ============================================================================
// Module   : sw_debounce3
// Purpose  : Synchronise and debounce three raw switch inputs (a, b, c).
//            Define SW_DEBOUNCE_RISE_EN to build the rising-edge strobes;
//            otherwise rise_o is tied low. Ports are identical in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module sw_debounce3
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] sw_i,
  output logic [NUM_SW-1:0] db_o,
  output logic [NUM_SW-1:0] rise_o,
  output logic              busy_o
);

  logic [NUM_SW-1:0] w_busy;
`ifdef SW_DEBOUNCE_RISE_EN
  logic [NUM_SW-1:0] w_rise_set;
`endif

  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_chan
      debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_chan (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw_i[gi]),
`ifdef SW_DEBOUNCE_RISE_EN
        .rise_set (w_rise_set[gi]),
`endif
        .db       (db_o[gi]),
        .busy     (w_busy[gi])
      );
    end : g_chan
  endgenerate

  assign busy_o = |w_busy;

`ifdef SW_DEBOUNCE_RISE_EN
  logic [NUM_SW-1:0] r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rise <= '0;
    end else begin
      r_rise <= w_rise_set;
    end
  end

  assign rise_o = r_rise;
`else
  assign rise_o = '0;
`endif

endmodule : sw_debounce3
`default_nettype wire
